// File: rtl/sp_if_ddr_arb_pkg.sv
// Shared types and default sizes for the DDR request-channel arbiter.
package sp_if_ddr_arb_pkg;

    localparam int DEF_N_REQ  = 4;
    localparam int DEF_AREA_W = 4;
    localparam int DEF_ADDR_W = 27;
    localparam int DEF_SIZE_W = 32;
    localparam int DEF_TMO_W  = 24;

    // Arbiter sequencing: pick a request, wait for the DDR to finish, retire it.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    // One DDR access descriptor at the default field widths.
    typedef struct packed {
        logic                  wxr;
        logic [DEF_AREA_W-1:0] area;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_SIZE_W-1:0] size;
    } ddr_req_t;

endpackage

// File: rtl/sp_if_rr_pick.sv
// Combinational round-robin picker: first pending requester at or after ptr,
// wrapping from N_REQ-1 back to 0.
module sp_if_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] pend,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    idx,
    output logic             vld
);

    int j;

    // Scan offsets from farthest to nearest so the nearest pending index wins.
    always_comb begin
        idx = '0;
        vld = 1'b0;
        j   = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (pend[j]) begin
                idx = IW'(j);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sp_if_ddr_arb.sv
// Round-robin arbiter sharing one DDR access-request channel between N_REQ
// requesters. Start pulses are latched with their parameters into per-requester
// shadow registers; one access runs at a time, guarded by a timeout watchdog.
module sp_if_ddr_arb
    import sp_if_ddr_arb_pkg::*;
#(
    parameter int               N_REQ   = DEF_N_REQ,
    parameter int               AREA_W  = DEF_AREA_W,
    parameter int               ADDR_W  = DEF_ADDR_W,
    parameter int               SIZE_W  = DEF_SIZE_W,
    parameter int               TMO_W   = DEF_TMO_W,
    parameter logic [TMO_W-1:0] TMO_CYC = 24'hFFFFFF,
    localparam int              IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                     i_clk156m,
    input  logic                     i_arst,
    input  logic [N_REQ-1:0]         i_req_start,
    input  logic [N_REQ-1:0]         i_req_wxr,
    input  logic [N_REQ*AREA_W-1:0]  i_req_area,
    input  logic [N_REQ*ADDR_W-1:0]  i_req_addr,
    input  logic [N_REQ*SIZE_W-1:0]  i_req_size,
    output logic [N_REQ-1:0]         o_req_endp,
    output logic [N_REQ-1:0]         o_req_pend,
    output logic                     o_ddr_wxr,
    output logic [AREA_W-1:0]        o_ddr_area,
    output logic [ADDR_W-1:0]        o_ddr_addr,
    output logic [SIZE_W-1:0]        o_ddr_size,
    output logic                     o_ddr_start,
    input  logic                     i_ddr_endp,
    output logic [IW-1:0]            o_grant,
    output logic                     o_busy,
    output logic [N_REQ-1:0]         o_err_ovf,
    output logic [N_REQ-1:0]         o_err_tmo,
    output logic                     o_err_spur
);

    typedef struct packed {
        logic              wxr;
        logic [AREA_W-1:0] area;
        logic [ADDR_W-1:0] addr;
        logic [SIZE_W-1:0] size;
    } desc_t;

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic [N_REQ-1:0]  pend_q;
    desc_t             shadow_q [N_REQ];
    logic [IW-1:0]     ptr_q;
    logic [IW-1:0]     pick_idx;
    logic              pick_vld;
    logic              pick_zero;
    logic [TMO_W-1:0]  wd_q;
    logic              tmo_hit;

    assign o_req_pend = pend_q;
    assign pick_zero  = (shadow_q[pick_idx].size == '0);
    assign tmo_hit    = (wd_q == TMO_CYC - TMO_W'(1));

    sp_if_rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .pend (pend_q),
        .ptr  (ptr_q),
        .idx  (pick_idx),
        .vld  (pick_vld)
    );

    // Latch start pulses; a start during its own retire cycle re-arms the slot.
    always_ff @(posedge i_clk156m) begin
        if (i_arst) begin
            pend_q    <= '0;
            o_err_ovf <= '0;
            for (int k = 0; k < N_REQ; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                if (i_req_start[k] && (!pend_q[k] || o_req_endp[k])) begin
                    pend_q[k]        <= 1'b1;
                    shadow_q[k].wxr  <= i_req_wxr[k];
                    shadow_q[k].area <= i_req_area[k*AREA_W +: AREA_W];
                    shadow_q[k].addr <= i_req_addr[k*ADDR_W +: ADDR_W];
                    shadow_q[k].size <= i_req_size[k*SIZE_W +: SIZE_W];
                end else begin
                    if (o_req_endp[k]) begin
                        pend_q[k] <= 1'b0;
                    end
                    if (i_req_start[k]) begin
                        o_err_ovf[k] <= 1'b1;
                    end
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk156m) begin
        if (i_arst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: zero-size requests retire without touching the DDR.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pick_vld) state_d = pick_zero ? ST_DONE : ST_WAIT;
            ST_WAIT: if (i_ddr_endp || tmo_hit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: completion pulse to the granted requester during DONE.
    always_comb begin
        o_busy     = (state_q != ST_IDLE);
        o_req_endp = '0;
        if (state_q == ST_DONE) begin
            o_req_endp[o_grant] = 1'b1;
        end
    end

    // DDR port, grant, watchdog, RR pointer and sticky fault flags.
    always_ff @(posedge i_clk156m) begin
        if (i_arst) begin
            o_ddr_wxr   <= 1'b0;
            o_ddr_area  <= '0;
            o_ddr_addr  <= '0;
            o_ddr_size  <= '0;
            o_ddr_start <= 1'b0;
            o_grant     <= '0;
            ptr_q       <= '0;
            wd_q        <= '0;
            o_err_tmo   <= '0;
            o_err_spur  <= 1'b0;
        end else begin
            o_ddr_start <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld) begin
                        o_grant <= pick_idx;
                        wd_q    <= '0;
                        if (!pick_zero) begin
                            o_ddr_wxr   <= shadow_q[pick_idx].wxr;
                            o_ddr_area  <= shadow_q[pick_idx].area;
                            o_ddr_addr  <= shadow_q[pick_idx].addr;
                            o_ddr_size  <= shadow_q[pick_idx].size;
                            o_ddr_start <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    wd_q <= wd_q + TMO_W'(1);
                    if (!i_ddr_endp && tmo_hit) begin
                        o_err_tmo[o_grant] <= 1'b1;
                    end
                end
                ST_DONE: begin
                    ptr_q <= (o_grant == IW'(N_REQ - 1)) ? '0 : o_grant + IW'(1);
                end
                default: ;
            endcase
            if (i_ddr_endp && (state_q != ST_WAIT)) begin
                o_err_spur <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sp_if_ddr_arb.sv
// Directed testbench for sp_if_ddr_arb. The main instance uses the default
// watchdog limit; a second instance with TMO_CYC=16 exercises the abort path.
module tb_sp_if_ddr_arb;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_start, req_wxr, t_start;
    logic [15:0]  req_area;
    logic [107:0] req_addr;
    logic [127:0] req_size;
    logic         ddr_endp;

    logic [3:0]  req_endp, req_pend, err_ovf, err_tmo;
    logic        ddr_wxr, ddr_start, busy, err_spur;
    logic [3:0]  ddr_area;
    logic [26:0] ddr_addr;
    logic [31:0] ddr_size;
    logic [1:0]  grant;

    logic [3:0]  t_req_endp, t_req_pend, t_err_ovf, t_err_tmo;
    logic        t_ddr_wxr, t_ddr_start, t_busy, t_err_spur;
    logic [3:0]  t_ddr_area;
    logic [26:0] t_ddr_addr;
    logic [31:0] t_ddr_size;
    logic [1:0]  t_grant;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sp_if_ddr_arb dut (
        .i_clk156m(clk), .i_arst(rst), .i_req_start(req_start), .i_req_wxr(req_wxr),
        .i_req_area(req_area), .i_req_addr(req_addr), .i_req_size(req_size),
        .o_req_endp(req_endp), .o_req_pend(req_pend), .o_ddr_wxr(ddr_wxr),
        .o_ddr_area(ddr_area), .o_ddr_addr(ddr_addr), .o_ddr_size(ddr_size),
        .o_ddr_start(ddr_start), .i_ddr_endp(ddr_endp), .o_grant(grant), .o_busy(busy),
        .o_err_ovf(err_ovf), .o_err_tmo(err_tmo), .o_err_spur(err_spur)
    );

    sp_if_ddr_arb #(.TMO_CYC(24'd16)) tdut (
        .i_clk156m(clk), .i_arst(rst), .i_req_start(t_start), .i_req_wxr(req_wxr),
        .i_req_area(req_area), .i_req_addr(req_addr), .i_req_size(req_size),
        .o_req_endp(t_req_endp), .o_req_pend(t_req_pend), .o_ddr_wxr(t_ddr_wxr),
        .o_ddr_area(t_ddr_area), .o_ddr_addr(t_ddr_addr), .o_ddr_size(t_ddr_size),
        .o_ddr_start(t_ddr_start), .i_ddr_endp(1'b0), .o_grant(t_grant), .o_busy(t_busy),
        .o_err_ovf(t_err_ovf), .o_err_tmo(t_err_tmo), .o_err_spur(t_err_spur)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic w, input logic [3:0] a,
                           input logic [26:0] ad, input logic [31:0] s);
        req_wxr[k]          = w;
        req_area[k*4 +: 4]  = a;
        req_addr[k*27 +: 27] = ad;
        req_size[k*32 +: 32] = s;
    endtask

    task automatic do_reset;
        rst = 1'b1; req_start = '0; t_start = '0; ddr_endp = 1'b0;
        tick; tick;
        rst = 1'b0;
    endtask

    // Ticks until the main DUT raises o_ddr_start; -1 if it never does.
    task automatic wait_start(output int n);
        n = -1;
        for (int i = 0; i < 40 && n < 0; i++) begin
            if (ddr_start) n = i;
            else tick;
        end
    endtask

    task automatic test_reset;
        req_wxr = '1; req_area = '1; req_addr = '1; req_size = '1;
        do_reset;
        total++; if (req_pend !== 4'h0) begin bad++; $display("FAIL rst_pend got=%h exp=0", req_pend); end
        total++; if (req_endp !== 4'h0) begin bad++; $display("FAIL rst_endp got=%h exp=0", req_endp); end
        total++; if ({ddr_wxr, ddr_area, ddr_addr, ddr_size} !== '0) begin bad++; $display("FAIL rst_ddr got=%h exp=0", ddr_addr); end
        total++; if ({ddr_start, busy, grant} !== 4'h0) begin bad++; $display("FAIL rst_ctl got=%b exp=0", {ddr_start, busy, grant}); end
        total++; if ({err_ovf, err_tmo, err_spur} !== 9'h0) begin bad++; $display("FAIL rst_err got=%h exp=0", {err_ovf, err_tmo, err_spur}); end
    endtask

    task automatic test_single;
        do_reset;
        set_req(1, 1'b0, 4'h3, 27'h100, 32'h4000);
        req_start = 4'b0010; tick; req_start = '0;
        total++; if ({req_pend, ddr_start} !== 5'b00100) begin bad++; $display("FAIL single_lat1 got=%b exp=00100", {req_pend, ddr_start}); end
        tick;
        total++; if (ddr_start !== 1'b1) begin bad++; $display("FAIL single_start got=%b exp=1", ddr_start); end
        total++; if ({ddr_wxr, ddr_area, ddr_addr, ddr_size} !== {1'b0, 4'h3, 27'h100, 32'h4000}) begin bad++; $display("FAIL single_desc got=%h/%h exp=100/4000", ddr_addr, ddr_size); end
        total++; if (grant !== 2'd1) begin bad++; $display("FAIL single_grant got=%0d exp=1", grant); end
        tick;
        total++; if (ddr_start !== 1'b0) begin bad++; $display("FAIL single_pulse got=%b exp=0", ddr_start); end
        repeat (46) tick;
        total++; if ({busy, req_endp, ddr_addr} !== {1'b1, 4'h0, 27'h100}) begin bad++; $display("FAIL single_hold got=%b/%h exp=1/0", busy, req_endp); end
        ddr_endp = 1'b1; tick; ddr_endp = 1'b0;
        total++; if (req_endp !== 4'b0010) begin bad++; $display("FAIL single_endp got=%b exp=0010", req_endp); end
        tick;
        total++; if ({req_endp, req_pend, busy} !== 9'h0) begin bad++; $display("FAIL single_retire got=%b exp=0", {req_endp, req_pend, busy}); end
        total++; if ({err_ovf, err_tmo, err_spur} !== 9'h0) begin bad++; $display("FAIL single_err got=%h exp=0", {err_ovf, err_tmo, err_spur}); end
    endtask

    task automatic test_fairness;
        int exp_seq [9];
        logic [3:0] masks [3];
        int cnt [3];
        int pos, n, e;
        exp_seq = '{0, 1, 2, 3, 1, 2, 3, 0, 1};
        masks   = '{4'hF, 4'h2, 4'hF};
        cnt     = '{4, 1, 4};
        pos     = 0;
        do_reset;
        for (int ph = 0; ph < 3; ph++) begin
            for (int k = 0; k < 4; k++) begin
                set_req(k, (k % 2) == 1, 4'(k + ph), 27'((k + 1) * 'h1000 + ph), 32'((k + 1) * 'h40));
            end
            req_start = masks[ph]; tick; req_start = '0;
            for (int g = 0; g < cnt[ph]; g++) begin
                wait_start(n);
                e = exp_seq[pos];
                total++; if (n !== ((g == 0) ? 1 : 2)) begin bad++; $display("FAIL fair_gap[%0d] got=%0d exp=%0d", pos, n, (g == 0) ? 1 : 2); end
                total++; if (grant !== 2'(e)) begin bad++; $display("FAIL fair_grant[%0d] got=%0d exp=%0d", pos, grant, e); end
                total++; if (ddr_addr !== 27'((e + 1) * 'h1000 + ph)) begin bad++; $display("FAIL fair_addr[%0d] got=%h exp=%h", pos, ddr_addr, (e + 1) * 'h1000 + ph); end
                pos++;
                repeat (9) tick;
                ddr_endp = 1'b1; tick; ddr_endp = 1'b0;
            end
            tick;
        end
        total++; if ({req_pend, busy, err_ovf} !== 9'h0) begin bad++; $display("FAIL fair_idle got=%b exp=0", {req_pend, busy, err_ovf}); end
    endtask

    task automatic test_overflow;
        int n;
        do_reset;
        set_req(1, 1'b1, 4'h1, 27'h700, 32'h100);
        req_start = 4'b0010; tick; req_start = '0; tick;
        set_req(2, 1'b0, 4'h2, 27'h10, 32'h80);
        req_start = 4'b0100; tick;
        set_req(2, 1'b0, 4'h2, 27'h20, 32'h80);
        tick; req_start = '0;
        total++; if (err_ovf !== 4'b0100) begin bad++; $display("FAIL ovf_flag got=%b exp=0100", err_ovf); end
        ddr_endp = 1'b1; tick; ddr_endp = 1'b0;
        set_req(1, 1'b1, 4'h1, 27'h50, 32'h100);
        req_start = 4'b0010; tick; req_start = '0;
        total++; if ({req_pend, err_ovf} !== 8'b0110_0100) begin bad++; $display("FAIL ovf_done_accept got=%b exp=01100100", {req_pend, err_ovf}); end
        wait_start(n);
        total++; if ({n == 1, grant, ddr_addr} !== {1'b1, 2'd2, 27'h10}) begin bad++; $display("FAIL ovf_addr got=%0d/%h exp=2/10", grant, ddr_addr); end
        repeat (3) tick;
        ddr_endp = 1'b1; tick; ddr_endp = 1'b0;
        wait_start(n);
        total++; if ({n == 2, grant, ddr_wxr, ddr_addr} !== {1'b1, 2'd1, 1'b1, 27'h50}) begin bad++; $display("FAIL ovf_rearm got=%0d/%h exp=1/50", grant, ddr_addr); end
        ddr_endp = 1'b1; tick; ddr_endp = 1'b0; tick;
    endtask

    task automatic test_timeout;
        do_reset;
        set_req(0, 1'b1, 4'h5, 27'h200, 32'h10);
        set_req(1, 1'b0, 4'h6, 27'h300, 32'h20);
        t_start = 4'b0011; tick; t_start = '0; tick;
        total++; if ({t_ddr_start, t_grant, t_ddr_wxr, t_ddr_area, t_ddr_size} !== {1'b1, 2'd0, 1'b1, 4'h5, 32'h10}) begin bad++; $display("FAIL tmo_first got=%b/%0d exp=1/0", t_ddr_start, t_grant); end
        repeat (15) tick;
        total++; if ({t_busy, t_req_endp, t_err_tmo} !== 9'b1_0000_0000) begin bad++; $display("FAIL tmo_early got=%b exp=100000000", {t_busy, t_req_endp, t_err_tmo}); end
        tick;
        total++; if ({t_req_endp, t_err_tmo} !== 8'b0001_0001) begin bad++; $display("FAIL tmo_abort got=%b exp=00010001", {t_req_endp, t_err_tmo}); end
        tick; tick;
        total++; if ({t_ddr_start, t_grant, t_ddr_addr} !== {1'b1, 2'd1, 27'h300}) begin bad++; $display("FAIL tmo_next got=%0d/%h exp=1/300", t_grant, t_ddr_addr); end
        total++; if ({t_req_pend, t_err_ovf, t_err_spur} !== 9'b0010_0000_0) begin bad++; $display("FAIL tmo_misc got=%b exp=001000000", {t_req_pend, t_err_ovf, t_err_spur}); end
    endtask

    task automatic test_zero_spur;
        do_reset;
        set_req(3, 1'b0, 4'h0, 27'h400, 32'h0);
        req_start = 4'b1000; tick; req_start = '0;
        total++; if (req_pend !== 4'b1000) begin bad++; $display("FAIL zero_pend got=%b exp=1000", req_pend); end
        tick;
        total++; if ({req_endp, ddr_start, busy} !== 6'b1000_0_1) begin bad++; $display("FAIL zero_endp got=%b exp=100001", {req_endp, ddr_start, busy}); end
        tick;
        total++; if ({req_pend, req_endp, ddr_start, busy, err_spur} !== 11'h0) begin bad++; $display("FAIL zero_retire got=%b exp=0", {req_pend, req_endp, ddr_start, busy, err_spur}); end
        ddr_endp = 1'b1; tick; ddr_endp = 1'b0;
        total++; if ({err_spur, err_tmo, busy} !== 6'b1_0000_0) begin bad++; $display("FAIL spur_idle got=%b exp=100000", {err_spur, err_tmo, busy}); end
    endtask

    task automatic test_reset_wait;
        do_reset;
        set_req(0, 1'b1, 4'hA, 27'h1234, 32'h800);
        req_start = 4'b0001; tick; req_start = '0; tick;
        total++; if ({ddr_start, ddr_addr} !== {1'b1, 27'h1234}) begin bad++; $display("FAIL rw_start got=%b/%h exp=1/1234", ddr_start, ddr_addr); end
        rst = 1'b1; tick; rst = 1'b0;
        total++; if ({req_endp, req_pend, ddr_wxr, ddr_area, ddr_addr, ddr_size, ddr_start, grant, busy} !== '0) begin bad++; $display("FAIL rw_clear got=%h/%b exp=0", ddr_addr, busy); end
        tick;
        total++; if ({busy, ddr_start, req_pend} !== 6'h0) begin bad++; $display("FAIL rw_stay got=%b exp=0", {busy, ddr_start, req_pend}); end
        ddr_endp = 1'b1; tick; ddr_endp = 1'b0;
        total++; if ({err_spur, err_ovf, err_tmo, req_endp} !== 13'b1_0000_0000_0000) begin bad++; $display("FAIL rw_spur got=%b exp=1000000000000", {err_spur, err_ovf, err_tmo, req_endp}); end
    endtask

    initial begin
        rst = 1'b1; req_start = '0; t_start = '0; ddr_endp = 1'b0;
        req_wxr = '0; req_area = '0; req_addr = '0; req_size = '0;
        test_reset;
        test_single;
        test_fairness;
        test_overflow;
        test_timeout;
        test_zero_spur;
        test_reset_wait;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

endmodule
